de1_blinker_led_seq: RTL

Avalon-MM controlled LED pattern sequencer for the DE1 blinker system. It holds a seed pattern, a prescaler period and a mode. In place of a plain PIO it drives the 8-bit LED bus with static, blink, rotate or bounce sequences, advancing one step per prescaler tick. Nios II software configures it through four 32-bit registers on the system interconnect.

---
 rtl/de1_blinker_led_seq_pkg.sv | 41 ++++
 rtl/de1_blinker_led_tick.sv | 48 ++++
 rtl/de1_blinker_led_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/de1_blinker_led_seq_pkg.sv
// de1_blinker_led_seq_pkg: shared constants and types for the LED pattern sequencer.
//   - Avalon-MM register addresses
//   - CTRL payload layout and mode encodings
//   - STATUS bit positions
//   - IDLE/RUN state encoding
package de1_blinker_led_seq_pkg;

    // Register map (word addresses on the 2-bit address bus)
    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Sequencing modes held in CTRL[2:1]
    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    // CTRL register payload: {mode, enable}
    localparam int unsigned CTRL_WIDTH = 3;
    typedef struct packed {
        mode_e mode;
        logic  enable;
    } ctrl_t;

    // STATUS register layout
    localparam int unsigned STATUS_OUT_LSB   = 0;
    localparam int unsigned STATUS_OUT_WIDTH = 8;
    localparam int unsigned STATUS_DIR_BIT   = 8;
    localparam int unsigned STATUS_RUN_BIT   = 9;

    // Sequencer state: tracks the committed enable bit
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/de1_blinker_led_tick.sv
// de1_blinker_led_tick: loadable prescaler down-counter producing the step strobe.
//   clk, reset : clock and synchronous active-high reset
//   run        : count down while high; hold at reload while low
//   load       : force the counter to reload (restart of a sequence)
//   reload     : prescaler period P; one tick every P+1 running cycles
//   tick       : high during the cycle in which the counter is zero
module de1_blinker_led_tick #(
    parameter int unsigned PRESCALE_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      load,
    input  logic [PRESCALE_WIDTH-1:0] reload,
    output logic                      tick
);

    localparam int unsigned PW = PRESCALE_WIDTH;

    logic [PW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count; tick is precomputed so it is a flop that is high exactly
    // while the registered count sits at zero.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (load || !run || (cnt_q == '0)) begin
            cnt_d = reload;
        end else begin
            cnt_d = cnt_q - PW'(1);
        end
        tick_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/de1_blinker_led_seq.sv
// de1_blinker_led_seq: Avalon-MM LED pattern sequencer (static/blink/rotate/bounce).
//   clk, reset  : clock and synchronous active-high reset
//   address     : register select (CTRL, PATTERN, PERIOD, STATUS)
//   chipselect  : slave select
//   write_n     : active-low write strobe
//   writedata   : 32-bit write data
//   readdata    : zero-wait-state combinational read mux
//   out_port    : registered LED drive
module de1_blinker_led_seq
    import de1_blinker_led_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned PW = PRESCALE_WIDTH;

    state_e        state_q, state_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [DW-1:0] pattern_q, pattern_d;
    logic [PW-1:0] period_q, period_d;
    logic [DW-1:0] cur_q, cur_d;
    logic          dir_q, dir_d;

    logic          wr_en, wr_ctrl, wr_pattern, wr_period;
    ctrl_t         wr_ctrl_data;
    logic          restart;
    logic          tick;
    logic [DW-1:0] step_cur;
    logic          step_dir;

    // Only the low register bits are stored; the rest of the bus is ignored.
    logic          unused_wdata;
    assign unused_wdata = ^writedata;

    // Bus write decode
    assign wr_en        = chipselect && !write_n;
    assign wr_ctrl      = wr_en && (address == ADDR_CTRL);
    assign wr_pattern   = wr_en && (address == ADDR_PATTERN);
    assign wr_period    = wr_en && (address == ADDR_PERIOD);
    assign wr_ctrl_data = ctrl_t'(writedata[CTRL_WIDTH-1:0]);

    // One step of the current mode applied to the step register
    always_comb begin
        step_cur = cur_q;
        step_dir = dir_q;
        unique case (ctrl_q.mode)
            MODE_STATIC: step_cur = pattern_q;
            MODE_BLINK:  step_cur = cur_q ^ pattern_q;
            MODE_ROTATE: step_cur = {cur_q[DW-2:0], cur_q[DW-1]};
            MODE_BOUNCE: begin
                // Reverse at an end bit; if the far end is also set, hold the
                // pattern so no set bit is ever shifted out.
                if (!dir_q) begin
                    if (cur_q[DW-1]) begin
                        step_dir = 1'b1;
                        step_cur = cur_q[0] ? cur_q : (cur_q >> 1);
                    end else begin
                        step_cur = cur_q << 1;
                    end
                end else begin
                    if (cur_q[0]) begin
                        step_dir = 1'b0;
                        step_cur = cur_q[DW-1] ? cur_q : (cur_q << 1);
                    end else begin
                        step_cur = cur_q >> 1;
                    end
                end
            end
            default: step_cur = cur_q;
        endcase
    end

    // Register file, IDLE/RUN state and step register next-state
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        pattern_d = pattern_q;
        period_d  = period_q;
        cur_d     = cur_q;
        dir_d     = dir_q;
        restart   = 1'b0;

        if (wr_ctrl) begin
            ctrl_d = wr_ctrl_data;
        end
        if (wr_pattern) begin
            pattern_d = writedata[DW-1:0];
        end
        if (wr_period) begin
            period_d = writedata[PW-1:0];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wr_ctrl && wr_ctrl_data.enable) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end
            end
            ST_RUN: begin
                if (wr_ctrl && !wr_ctrl_data.enable) begin
                    state_d = ST_IDLE;
                end else if (wr_ctrl && (wr_ctrl_data.mode != ctrl_q.mode)) begin
                    restart = 1'b1;
                end else if (wr_pattern) begin
                    restart = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Restart and idle both reseed from the pattern; a restart beats a tick.
        if ((state_d == ST_IDLE) || restart) begin
            cur_d = pattern_d;
            dir_d = 1'b0;
        end else if (tick) begin
            cur_d = step_cur;
            dir_d = step_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            pattern_q <= '0;
            period_q  <= '0;
            cur_q     <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            pattern_q <= pattern_d;
            period_q  <= period_d;
            cur_q     <= cur_d;
            dir_q     <= dir_d;
        end
    end

    // Prescaler; reload follows the incoming PERIOD so a restart picks up
    // a value written in the same cycle.
    de1_blinker_led_tick #(
        .PRESCALE_WIDTH(PW)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .run    (state_q == ST_RUN),
        .load   (restart),
        .reload (period_d),
        .tick   (tick)
    );

    // Combinational read mux, unused bits zero
    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_CTRL:    readdata[CTRL_WIDTH-1:0] = ctrl_q;
            ADDR_PATTERN: readdata[DW-1:0]         = pattern_q;
            ADDR_PERIOD:  readdata[PW-1:0]         = period_q;
            ADDR_STATUS: begin
                readdata[STATUS_OUT_LSB +: STATUS_OUT_WIDTH] = STATUS_OUT_WIDTH'(cur_q);
                readdata[STATUS_DIR_BIT]                     = dir_q;
                readdata[STATUS_RUN_BIT]                     = (state_q == ST_RUN);
            end
            default: readdata = '0;
        endcase
    end

    // The step register mirrors PATTERN in IDLE, so it is the LED drive.
    assign out_port = cur_q;

endmodule
